// File: rtl/branch_decode_queue.sv
// -----------------------------------------------------------------------------
// branch_decode_queue
//
// Decodes B-form (bc, primary opcode 16) and I-form (b, primary opcode 18)
// branches. For each one it computes the branch target and the LR-save value,
// flags the CTR and LR side effects, and queues the result in a DEPTH-entry
// FIFO with valid/ready handshakes on both sides. A word with any other
// primary opcode is still accepted from upstream, but it is dropped. It is
// reported by a one-cycle error pulse and counted in a saturating error
// counter.
//
// Instruction bits follow big-endian numbering: inst[k] is instruction_i[31-k].
//
// Ports
//   clock_i, reset_i           clock (rising edge), async active-low reset
//   flush_i                    synchronous clear of the queued entries
//   valid_i / ready_o          upstream handshake (ready_o depends on count only)
//   instruction_i              raw instruction word
//   instructionAddress_i       instruction address
//   is64Bit_i                  1 = 64-bit mode, 0 = 32-bit address wrap
//   instructionPid_i/Tid_i/MajId_i   header fields carried with the entry
//   valid_o / ready_i          downstream handshake on the head entry
//   opcode_o .. is64Bit_o      decoded payload of the head entry
//   count_o                    current occupancy
//   decodeError_o              pulse one cycle after a rejected opcode
//   errorCount_o               saturating count of rejected opcodes
// -----------------------------------------------------------------------------
module branch_decode_queue #(
   parameter int addressWidth            = 64,
   parameter int instructionWidth        = 32,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int instructionCounterWidth = 64,
   parameter int opcodeSize              = 12,
   parameter int DEPTH                   = 4,
   parameter int BcDecodedOpcode         = 24,
   parameter int BDecodedOpcode          = 25,
   parameter int errCountWidth           = 16
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               valid_i,
   output logic                               ready_o,
   input  logic [instructionWidth-1:0]        instruction_i,
   input  logic [addressWidth-1:0]            instructionAddress_i,
   input  logic                               is64Bit_i,
   input  logic [PidSize-1:0]                 instructionPid_i,
   input  logic [TidSize-1:0]                 instructionTid_i,
   input  logic [instructionCounterWidth-1:0] instructionMajId_i,
   output logic                               valid_o,
   input  logic                               ready_i,
   output logic [opcodeSize-1:0]              opcode_o,
   output logic [addressWidth-1:0]            target_o,
   output logic [addressWidth-1:0]            lrValue_o,
   output logic [4:0]                         bo_o,
   output logic [4:0]                         bi_o,
   output logic                               usesCtr_o,
   output logic                               writesLr_o,
   output logic [instructionCounterWidth-1:0] majId_o,
   output logic [PidSize-1:0]                 pid_o,
   output logic [TidSize-1:0]                 tid_o,
   output logic                               is64Bit_o,
   output logic [$clog2(DEPTH):0]             count_o,
   output logic                               decodeError_o,
   output logic [errCountWidth-1:0]           errorCount_o
);

   localparam int PtrW = $clog2(DEPTH);
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0]          FullCount = CntW'(DEPTH);
   localparam logic [addressWidth-1:0]  Low32Mask = addressWidth'(64'hFFFF_FFFF);
   localparam logic [errCountWidth-1:0] ErrMax    = '1;

   typedef struct packed {
      logic [opcodeSize-1:0]              opcode;
      logic [addressWidth-1:0]            target;
      logic [addressWidth-1:0]            lr_value;
      logic [4:0]                         bo;
      logic [4:0]                         bi;
      logic                               uses_ctr;
      logic                               writes_lr;
      logic [instructionCounterWidth-1:0] maj_id;
      logic [PidSize-1:0]                 pid;
      logic [TidSize-1:0]                 tid;
      logic                               is_64bit;
   } entry_t;

   // ---------------------------------------------------------------- decode
   logic [5:0]              prim_op;
   logic                    is_bc;
   logic                    is_b;
   logic                    op_ok;
   logic [addressWidth-1:0] imm_bc;
   logic [addressWidth-1:0] imm_b;
   logic [addressWidth-1:0] imm;
   logic [addressWidth-1:0] target_raw;
   logic [addressWidth-1:0] lr_raw;
   entry_t                  dec_entry;

   assign prim_op = instruction_i[31:26];
   assign is_bc   = (prim_op == 6'd16);
   assign is_b    = (prim_op == 6'd18);
   assign op_ok   = is_bc | is_b;

   // BD is inst[16:29] and LI is inst[6:29]. Both are word offsets, so
   // the two low bits are zero.
   assign imm_bc = {{(addressWidth-16){instruction_i[15]}}, instruction_i[15:2], 2'b00};
   assign imm_b  = {{(addressWidth-26){instruction_i[25]}}, instruction_i[25:2], 2'b00};
   assign imm    = is_b ? imm_b : imm_bc;

   // AA = inst[30] selects an absolute target.
   assign target_raw = instruction_i[1] ? imm : (instructionAddress_i + imm);
   assign lr_raw     = instructionAddress_i + addressWidth'(4);

   always_comb begin
      dec_entry           = '0;
      dec_entry.opcode    = is_b ? opcodeSize'(BDecodedOpcode) : opcodeSize'(BcDecodedOpcode);
      // 32-bit mode: both addresses wrap at 2^32.
      dec_entry.target    = is64Bit_i ? target_raw : (target_raw & Low32Mask);
      dec_entry.lr_value  = is64Bit_i ? lr_raw : (lr_raw & Low32Mask);
      // An I-form branch behaves as branch-always: BO = 0b10100 and CTR is untouched.
      dec_entry.bo        = is_b ? 5'b10100 : instruction_i[25:21];
      dec_entry.bi        = is_b ? 5'b00000 : instruction_i[20:16];
      // BO bit 2 (inst[8]) clear means the branch decrements and tests CTR.
      dec_entry.uses_ctr  = is_bc & ~instruction_i[23];
      dec_entry.writes_lr = instruction_i[0];
      dec_entry.maj_id    = instructionMajId_i;
      dec_entry.pid       = instructionPid_i;
      dec_entry.tid       = instructionTid_i;
      dec_entry.is_64bit  = is64Bit_i;
   end

   // ------------------------------------------------------------------ fifo
   entry_t                   mem_q [DEPTH];
   logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]          count_q, count_d;
   logic                     decode_err_q, decode_err_d;
   logic [errCountWidth-1:0] err_cnt_q, err_cnt_d;
   logic                     push_hs;
   logic                     do_push;
   logic                     do_pop;
   logic                     reject;
   entry_t                   head;

   assign ready_o = (count_q != FullCount);
   assign valid_o = (count_q != '0);

   // A rejected word still completes the upstream handshake. Flush
   // overrides push, pop and error accounting in the same cycle.
   assign push_hs = valid_i & ready_o;
   assign do_push = push_hs & op_ok & ~flush_i;
   assign do_pop  = valid_o & ready_i & ~flush_i;
   assign reject  = push_hs & ~op_ok & ~flush_i;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      decode_err_d = reject;
      err_cnt_d    = err_cnt_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end

      if (reject && (err_cnt_q != ErrMax)) err_cnt_d = err_cnt_q + errCountWidth'(1);
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         decode_err_q <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         decode_err_q <= decode_err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   // Storage is cleared on reset so that the payload outputs read zero.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= dec_entry;
      end
   end

   // --------------------------------------------------------------- outputs
   assign head = mem_q[rd_ptr_q];

   assign opcode_o      = head.opcode;
   assign target_o      = head.target;
   assign lrValue_o     = head.lr_value;
   assign bo_o          = head.bo;
   assign bi_o          = head.bi;
   assign usesCtr_o     = head.uses_ctr;
   assign writesLr_o    = head.writes_lr;
   assign majId_o       = head.maj_id;
   assign pid_o         = head.pid;
   assign tid_o         = head.tid;
   assign is64Bit_o     = head.is_64bit;
   assign count_o       = count_q;
   assign decodeError_o = decode_err_q;
   assign errorCount_o  = err_cnt_q;

endmodule

// File: doc/branch_decode_queue.md
Name: branch_decode_queue

Overview:
- Parametrised successor to the single-format branch decoder: decodes both B-form (bc, primary opcode 16) and I-form (b, primary opcode 18) branches in one block.
- Computes the branch target address and the LR-save value, and flags CTR/LR side effects.
- Buffers decoded branches in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between the format-detect decode stage and the branch unit issue logic.

Parameters:
- addressWidth, 64, instruction/target address width.
- instructionWidth, 32, instruction word width.
- PidSize, 20, process ID width.
- TidSize, 16, thread ID width.
- instructionCounterWidth, 64, major ID width.
- opcodeSize, 12, decoded opcode width.
- DEPTH, 4, FIFO entries; power of two, >=2.
- BcDecodedOpcode, 24, decoded opcode emitted for bc.
- BDecodedOpcode, 25, decoded opcode emitted for b.
- errCountWidth, 16, width of the saturating error counter.

Ports:
- clock_i  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous clear of the FIFO contents.
- valid_i  input  1  input instruction is valid.
- ready_o  output 1  block can accept an input this cycle.
- instruction_i  input  instructionWidth  raw instruction, bit 0 = MSB.
- instructionAddress_i  input  addressWidth  instruction address.
- is64Bit_i  input  1  64-bit mode; 0 = 32-bit mode.
- instructionPid_i  input  PidSize  process ID.
- instructionTid_i  input  TidSize  thread ID.
- instructionMajId_i  input  instructionCounterWidth  major ID.
- valid_o  output 1  FIFO head holds a valid entry.
- ready_i  input  1  downstream accepts the head entry.
- opcode_o  output opcodeSize  decoded opcode.
- target_o  output addressWidth  branch target address.
- lrValue_o  output addressWidth  instruction address + 4.
- bo_o  output 5  BO field.
- bi_o  output 5  BI field.
- usesCtr_o  output 1  branch decrements and tests CTR.
- writesLr_o  output 1  LK set.
- majId_o, pid_o, tid_o, is64Bit_o  output  matching widths  passthrough of the input header fields.
- count_o  output clog2(DEPTH)+1  current occupancy.
- decodeError_o  output 1  one-cycle pulse on a rejected opcode.
- errorCount_o  output errCountWidth  saturating count of rejected opcodes.

Behaviour:
- Reset (reset_i=0, async) clears:
  - FIFO pointers, count_o, valid_o, decodeError_o, errorCount_o → 0.
  - All payload outputs → 0.
  - ready_o is 1 once reset deasserts.
- Handshakes:
  - ready_o = (count != DEPTH), combinational from count only; there is no same-cycle pop bypass when full.
  - Push on valid_i && ready_o; pop on valid_o && ready_i.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Latency: an entry accepted in cycle N is visible at the head in cycle N+1 when the FIFO was empty. Outputs are taken from registered storage at the head entry.
- Opcode check on instruction_i[0:5]:
  - 16 or 18: the decoded entry is pushed.
  - Any other value: not pushed; the input is still consumed (it counts as a push handshake).
  - On a rejected opcode, decodeError_o is 1 in cycle N+1 and errorCount_o increments, saturating at all-ones.
- B-form (opcode 16) fields:
  - bo_o = inst[6:10], bi_o = inst[11:15].
  - imm = sign-extended {inst[16:29], 2'b00}.
  - usesCtr_o = ~inst[8] (BO bit 2).
- I-form (opcode 18) fields:
  - bo_o = 5'b10100, bi_o = 0, usesCtr_o = 0.
  - imm = sign-extended {inst[6:29], 2'b00}.
- Both forms: AA = inst[30], writesLr_o = inst[31].
- Target and LR-save arithmetic:
  - target = AA ? imm : address + imm, modulo 2^addressWidth.
  - lrValue = address + 4, also modulo 2^addressWidth.
  - If is64Bit_i=0, target and lrValue have their upper addressWidth-32 bits forced to 0 (32-bit wrap).
- Flush (flush_i=1):
  - Pointers and count → 0; valid_o → 0 next cycle.
  - Flush takes priority over a same-cycle push or pop; the same-cycle input is dropped and not counted as an error.
  - errorCount_o is preserved.
- Held outputs: when valid_o=0, payload outputs hold their last value; the bench must not check them.
- Reset mid-transfer: all entries are lost immediately (asynchronous).

Test Plan:
- Reset then push 0x4082FFF8 at address 0x1000, is64Bit=1 → next cycle: valid_o=1, opcode_o=24, target_o=0xFF8, bo_o=0b00100, bi_o=2, usesCtr_o=0, writesLr_o=0, lrValue_o=0x1004.
- Push 0x48000403 at address 0x2000 → opcode_o=25, target_o=0x400 (absolute), writesLr_o=1, lrValue_o=0x2004, bo_o=0b10100, usesCtr_o=0.
- Push 0x48000008 at address 0xFFFFFFFC: with is64Bit=0 → target_o=0x4, lrValue_o=0x0; with is64Bit=1 → target_o=0x1_00000004.
- bc with BO=0b10000 (0x4200FFF0) → usesCtr_o=1.
- Push 0x7C000000 → nothing enqueued, decodeError_o pulses once, errorCount_o=1.
- Fill: hold ready_i=0 and push DEPTH valid branches → count_o=4, ready_o=0, a fifth valid_i is ignored. Then ready_i=1 with push each cycle → count_o stays at 3; order is preserved by majId_o.
- Flush with 3 entries plus a simultaneous push → count_o=0, valid_o=0 next cycle, errorCount_o unchanged.
- Assert reset_i=0 asynchronously mid-stream → count_o=0 and valid_o=0 without waiting for a clock edge.
